// File: rtl/imem_fetch_port.sv
// Instruction memory with a pipelined fetch port for the RISC-V fetch stage.
// A byte-enabled loader port fills the array; after reset an optional clear
// sequencer zero-fills every word before any fetch or load is accepted.
// Fetch results travel down a RD_LATENCY-deep pipeline together with their PC
// and error flag. A branch flush kills everything already in flight.

module imem_fetch_port #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_ready,
    input  logic          flush,
    output logic          fetch_valid,
    output logic [31:0]   fetch_data,
    output logic [AW-1:0] fetch_pc,
    output logic          fetch_err,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    input  logic [3:0]    ld_be,
    output logic          ld_ready,
    output logic          busy
);

    // Word index width; DEPTH need not be a power of two.
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("imem_fetch_port: RD_LATENCY must be in 1..4");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("imem_fetch_port: DEPTH must be at least 2");
    end

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;
    logic          clr_we;

    logic [31:0]   mem [DEPTH];

    // Fetch-side decode
    logic [AW-1:0] fetch_word;
    logic          fetch_in_range;
    logic          fetch_go;
    logic          new_err;
    logic [31:0]   new_data;

    // Loader-side decode
    logic [AW-1:0] ld_word;
    logic          ld_in_range;
    logic          ld_go;

    // Result pipeline: stage RD_LATENCY-1 drives the outputs.
    logic [RD_LATENCY-1:0] pv_q;
    logic [RD_LATENCY-1:0] perr_q;
    logic [AW-1:0]         ppc_q   [RD_LATENCY];
    logic [31:0]           pdata_q [RD_LATENCY];

    // Handshakes are gated by reset so nothing is offered while it is held,
    // even when the state register already sits in StRun.
    assign ld_ready    = reset && (state_q == StRun);
    assign fetch_ready = reset && (state_q == StRun) && !ld_wr;

    assign fetch_word     = fetch_addr >> 2;
    assign fetch_in_range = fetch_word < AW'(DEPTH);
    assign fetch_go       = fetch_req && fetch_ready;
    assign new_err        = (fetch_addr[1:0] != 2'b00) || !fetch_in_range;
    // Errored fetches return zero; out-of-range PCs never alias onto real words.
    assign new_data       = new_err ? 32'h0 : mem[fetch_word[IW-1:0]];

    assign ld_word     = ld_addr >> 2;
    assign ld_in_range = ld_word < AW'(DEPTH);
    assign ld_go       = ld_wr && ld_ready && ld_in_range;

    assign fetch_valid = pv_q[RD_LATENCY-1];
    assign fetch_err   = perr_q[RD_LATENCY-1];
    assign fetch_pc    = ppc_q[RD_LATENCY-1];
    assign fetch_data  = pdata_q[RD_LATENCY-1];

    assign busy = (state_q == StClear) || (|pv_q);

    // State register and clear counter; reset restarts the clear walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (CLEAR_ON_RESET) begin
                state_q <= StClear;
            end else begin
                state_q <= StRun;
            end
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: walk every word once in StClear, then stay in StRun.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            StClear: begin
                clr_we    = reset;
                clr_idx_d = clr_idx_q + IW'(1);
                if (clr_idx_q == LastIdx) begin
                    state_d   = StRun;
                    clr_idx_d = '0;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Memory array: clear writes or byte-enabled loader writes, never both.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx_q] <= '0;
        end else if (ld_go) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be[b]) begin
                    mem[ld_word[IW-1:0]][8*b +: 8] <= ld_wdata[8*b +: 8];
                end
            end
        end
    end

    // Result pipeline: payloads only move with a live valid bit so the
    // outputs hold their last result between pulses; flush kills older stages
    // but the fetch accepted alongside it still enters stage 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_q   <= '0;
            perr_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                ppc_q[i]   <= '0;
                pdata_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= fetch_go;
            if (fetch_go) begin
                ppc_q[0]   <= fetch_addr;
                perr_q[0]  <= new_err;
                pdata_q[0] <= new_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1] && !flush;
                if (pv_q[i-1] && !flush) begin
                    ppc_q[i]   <= ppc_q[i-1];
                    perr_q[i]  <= perr_q[i-1];
                    pdata_q[i] <= pdata_q[i-1];
                end
            end
        end
    end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Synchronous, parametrised instruction memory feeding the fetch stage of the RISC-V pipeline.
- Provides a pipelined fetch port with request/valid handshake, configurable read latency, branch flush and error reporting for misaligned or out-of-range PCs.
- Provides a byte-enabled loader write port for the testbench or boot loader.
- Has a post-reset clear sequencer, so the fetch unit only sees defined contents.

Parameters:
- AW, 32, width of fetch and loader addresses (bytes).
- DEPTH, 1024, number of 32-bit instruction words; need not be a power of two.
- RD_LATENCY, 1, cycles from accepted fetch to fetch_valid; legal range 1..4.
- CLEAR_ON_RESET, 1, when 1 the memory is zero-filled after reset before any access is accepted.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  AW  byte PC to fetch.
- fetch_ready  out  1  fetch is accepted when fetch_req && fetch_ready.
- flush  in  1  kill all in-flight fetches (branch/jump taken).
- fetch_valid  out  1  one-cycle pulse, result present.
- fetch_data  out  32  instruction word.
- fetch_pc  out  AW  PC of the returned word.
- fetch_err  out  1  returned PC was misaligned or out of range.
- ld_wr  in  1  loader write strobe.
- ld_addr  in  AW  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_be  in  4  byte enables; bit i writes ld_wdata[8i+7:8i].
- ld_ready  out  1  a loader write is performed when ld_wr && ld_ready.
- busy  out  1  clearing in progress, or any fetch in flight.

Behaviour:
- Reset values (asynchronous, while reset = 0):
  - fetch_valid = 0, fetch_data = 0, fetch_pc = 0, fetch_err = 0.
  - fetch_ready = 0, ld_ready = 0.
  - All pipeline valid bits = 0.
  - busy = CLEAR_ON_RESET.
- FSM state after reset release: CLEAR if CLEAR_ON_RESET = 1, else RUN.
- CLEAR state:
  - Counter idx walks 0..DEPTH-1, writing one zero word per cycle.
  - When idx = DEPTH-1 is written, go to RUN on the next edge; CLEAR lasts exactly DEPTH cycles.
  - fetch_ready = 0 and ld_ready = 0 throughout.
- RUN state:
  - Never leaves RUN except via reset.
  - ld_ready = 1.
  - fetch_ready = !ld_wr; the loader has priority, so a read and a write never occur in the same cycle.
- Word index = addr >> 2.
- Loader write:
  - Address bits [1:0] are ignored.
  - If index >= DEPTH the write is dropped silently.
  - ld_be = 0 is a no-op.
  - A fetch accepted in the cycle after a write to the same word returns the new data.
- Fetch pipeline:
  - An accepted request enters a RD_LATENCY-deep shift register of {valid, pc, err}.
  - fetch_valid, fetch_data, fetch_pc and fetch_err appear exactly RD_LATENCY cycles after acceptance, held for one cycle.
  - Throughput is one fetch per cycle; back-to-back results emerge on consecutive cycles in request order.
  - With no result, fetch_valid = 0 and the data/pc/err outputs hold their previous values.
- Error handling:
  - err = (addr[1:0] != 0) || (index >= DEPTH).
  - On err, fetch_data = 0. Out-of-range addresses do not alias or wrap.
- Flush:
  - Clears every pipeline valid bit at the edge; no result for any previously accepted fetch is ever returned.
  - A request accepted in the same cycle as flush is NOT killed; it is the new target.
- busy = (state == CLEAR) || any pipeline valid bit set.
- Reset asserted mid-fetch or mid-clear:
  - In-flight results are discarded.
  - The FSM restarts in CLEAR (or RUN).
  - With CLEAR_ON_RESET = 0, memory contents are retained.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16 -> ld_ready rises exactly 16 cycles after reset release; fetch of 0x3C returns 0x00000000.
- Load 0x00100093 at 0x0, 0x00200113 at 0x4; fetch 0x0 and 0x4 on consecutive cycles, RD_LATENCY=2 -> valid on cycles +2 and +3, data in order, fetch_pc 0x0 then 0x4.
- Load 0xFFFFFFFF at 0x8, then write 0x00000000 to 0x8 with ld_be=4'b0101 -> fetch 0x8 returns 0xFF00FF00.
- Fetch 0x6 -> fetch_err=1, data 0. Fetch 0x40 with DEPTH=16 -> fetch_err=1, data 0. Write to 0x40 -> word 0 unchanged.
- RD_LATENCY=3: fetch 0x0, 0x4, then flush together with a fetch of 0x10 -> only 0x10 is returned, 3 cycles after its acceptance.
- ld_wr held high while fetch_req=1 -> fetch_ready=0, no fetch accepted. Reset pulsed with fetches in flight -> fetch_valid never asserts for them.
